// File: rtl/z80_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module      : z80_mem_bridge
// Description : Bridges a tv80s-style Z80 bus to a simple req/ack memory
//               port. Each CPU bus cycle becomes one memory request. The CPU
//               is held with cpu_wait_n until the memory acknowledges, or
//               until a timeout sets the sticky bus_err flag.
//               Define Z80_BRIDGE_IO_EN to forward IO cycles to memory page
//               0x10xx. Without it, IO reads return 0xFF, IO writes are
//               dropped, and the CPU is not stalled.
// Revision    : 1.0  initial release
// ============================================================================
module z80_mem_bridge #(
  parameter int MIN_WAIT = 0,   // extra wait cycles after each mem_ack (0-15)
  parameter int TIMEOUT  = 255  // max cycles mem_req waits for mem_ack (1-255)
) (
  input  logic        clk,
  input  logic        reset_n,
  // tv80s bus
  input  logic [15:0] cpu_a,
  input  logic [7:0]  cpu_do,
  input  logic        cpu_mreq_n,
  input  logic        cpu_iorq_n,
  input  logic        cpu_rd_n,
  input  logic        cpu_wr_n,
  input  logic        cpu_m1_n,
  input  logic        cpu_rfsh_n,
  output logic [7:0]  cpu_di,
  output logic        cpu_wait_n,
  // memory side
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  // status
  output logic        bus_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_XWAIT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Terminal counts. The counter starts at 0, so the last cycle is N-1.
  localparam logic [7:0] TIMEOUT_LAST  = 8'(TIMEOUT - 1);
  localparam logic [7:0] MIN_WAIT_LAST = (MIN_WAIT > 0) ? 8'(MIN_WAIT - 1) : 8'd0;
  localparam bit         HAS_XWAIT     = (MIN_WAIT > 0);

  state_t      state;
  state_t      state_next;
  logic [7:0]  cnt;          // shared timeout / extra-wait counter

  logic        strobe;       // a read or write strobe is active
  logic        mem_start;    // memory access (refresh excluded)
  logic        io_start;     // IO access (interrupt acknowledge excluded)
  logic        inta;         // interrupt acknowledge cycle
  logic        start;        // access that produces a memory request
  logic        ff_load;      // cycle answered locally with 0xFF
  logic [15:0] start_addr;   // address to present for this access

  logic        busy;         // CPU must be stalled this cycle
  logic        take_ack;     // acknowledge accepted this cycle
  logic        timeout_hit;  // request abandoned this cycle

  // Bus cycle decode
  assign strobe    = !cpu_rd_n || !cpu_wr_n;
  assign mem_start = !cpu_mreq_n && cpu_rfsh_n && strobe;
  assign io_start  = !cpu_iorq_n && cpu_m1_n && strobe;
  assign inta      = !cpu_iorq_n && !cpu_m1_n;

`ifdef Z80_BRIDGE_IO_EN
  // IO cycles are forwarded into the 0x10xx window of memory space.
  assign start      = mem_start || io_start;
  assign start_addr = mem_start ? cpu_a : {8'h10, cpu_a[7:0]};
  assign ff_load    = inta;
`else
  // IO cycles never reach memory; reads see an idle (0xFF) bus.
  assign start      = mem_start;
  assign start_addr = cpu_a;
  assign ff_load    = inta || (io_start && !cpu_rd_n);
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode, handshake events and the combinational wait line
  always_comb begin
    state_next  = state;
    busy        = 1'b0;
    take_ack    = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      S_IDLE: begin
        busy = start;
        if (start) begin
          state_next = S_REQ;
        end
      end
      S_REQ: begin
        busy = 1'b1;
        // An ack in the last allowed cycle still wins over the timeout.
        if (mem_ack && mem_req) begin
          take_ack   = 1'b1;
          state_next = HAS_XWAIT ? S_XWAIT : S_DONE;
        end else if (cnt == TIMEOUT_LAST) begin
          timeout_hit = 1'b1;
          state_next  = S_DONE;
        end
      end
      S_XWAIT: begin
        busy = 1'b1;
        if (cnt == MIN_WAIT_LAST) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        // Wait for the CPU to end its bus cycle so one cycle gives one request.
        if (cpu_mreq_n && cpu_iorq_n) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
    cpu_wait_n = !reset_n || !busy;
  end

  // Request registers, read-data latch, counter and error flag
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 16'h0000;
      mem_wdata <= 8'h00;
      cpu_di    <= 8'hFF;
      bus_err   <= 1'b0;
      cnt       <= 8'd0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt <= 8'd0;
          if (start) begin
            mem_req   <= 1'b1;
            mem_we    <= !cpu_wr_n;
            mem_addr  <= start_addr;
            mem_wdata <= cpu_do;
          end else if (ff_load) begin
            cpu_di <= 8'hFF;
          end
        end
        S_REQ: begin
          if (take_ack) begin
            mem_req <= 1'b0;
            cnt     <= 8'd0;
            if (!mem_we) begin
              cpu_di <= mem_rdata;
            end
          end else if (timeout_hit) begin
            mem_req <= 1'b0;
            bus_err <= 1'b1;
            cnt     <= 8'd0;
            if (!mem_we) begin
              cpu_di <= 8'hFF;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_XWAIT: begin
          cnt <= cnt + 8'd1;
        end
        S_DONE: begin
          cnt <= 8'd0;
        end
        default: begin
          cnt <= 8'd0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_z80_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_z80_mem_bridge
// Description : Self-checking bench for z80_mem_bridge. Unit 0 uses default
//               parameters; unit 1 uses MIN_WAIT=2, TIMEOUT=4.
// Revision    : 1.0  initial release
// ============================================================================
module tb_z80_mem_bridge;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] cpu_a;
  logic [7:0]  cpu_do;
  logic        mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n;
  logic        mreq2_n, rd2_n, wr2_n;

  logic [7:0]  cpu_di, cpu_di2;
  logic        wait_n, wait2_n;
  logic        mem_req, mem_req2, mem_we, mem_we2;
  logic [15:0] mem_addr, mem_addr2;
  logic [7:0]  mem_wdata, mem_wdata2;
  logic        bus_err, bus_err2;
  logic        mem_ack, mem_ack2;
  logic [7:0]  mem_rdata, mem_rdata2;

  always #5 clk = ~clk;

  z80_mem_bridge dut (
    .clk(clk), .reset_n(reset_n), .cpu_a(cpu_a), .cpu_do(cpu_do),
    .cpu_mreq_n(mreq_n), .cpu_iorq_n(iorq_n), .cpu_rd_n(rd_n), .cpu_wr_n(wr_n),
    .cpu_m1_n(m1_n), .cpu_rfsh_n(rfsh_n), .cpu_di(cpu_di), .cpu_wait_n(wait_n),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .bus_err(bus_err)
  );

  z80_mem_bridge #(.MIN_WAIT(2), .TIMEOUT(4)) dut2 (
    .clk(clk), .reset_n(reset_n), .cpu_a(cpu_a), .cpu_do(cpu_do),
    .cpu_mreq_n(mreq2_n), .cpu_iorq_n(1'b1), .cpu_rd_n(rd2_n), .cpu_wr_n(wr2_n),
    .cpu_m1_n(1'b1), .cpu_rfsh_n(1'b1), .cpu_di(cpu_di2), .cpu_wait_n(wait2_n),
    .mem_req(mem_req2), .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
    .mem_ack(mem_ack2), .mem_rdata(mem_rdata2), .bus_err(bus_err2)
  );

  // Memory device contents and the bench's own view of what memory should hold
  logic [7:0]  tb_mem  [0:65535];
  logic [7:0]  ref_mem [0:65535];

  // Memory responder state, one slot per unit
  int          dly      [2] = '{1, 1};
  bit          en       [2] = '{1'b1, 1'b1};
  bit          spur = 1'b0;
  int          req_cnt  [2] = '{0, 0};
  int          rises    [2] = '{0, 0};
  bit          prev_req [2] = '{1'b0, 1'b0};
  logic [15:0] last_addr  [2];
  logic        last_we    [2];
  logic [7:0]  last_wdata [2];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory model: ack in the dly-th cycle of a request; spur injects an ack while idle
  task automatic respond(input int i, input logic req, input logic we, input logic [15:0] addr,
                         input logic [7:0] wd, output logic ack, output logic [7:0] rdata);
    ack   = 1'b0;
    rdata = 8'($urandom);
    if (req && !prev_req[i]) rises[i]++;
    prev_req[i] = req;
    if (req) begin
      req_cnt[i]++;
      if (en[i] && req_cnt[i] == dly[i]) begin
        ack           = 1'b1;
        last_addr[i]  = addr;
        last_we[i]    = we;
        last_wdata[i] = wd;
        if (we) tb_mem[addr] = wd;
        else    rdata = tb_mem[addr];
      end
    end else begin
      req_cnt[i] = 0;
      if (spur) begin
        ack   = 1'b1;
        rdata = 8'h55;
      end
    end
  endtask

  always @(negedge clk) respond(0, mem_req,  mem_we,  mem_addr,  mem_wdata,  mem_ack,  mem_rdata);
  always @(negedge clk) respond(1, mem_req2, mem_we2, mem_addr2, mem_wdata2, mem_ack2, mem_rdata2);

  task automatic poke(input logic [15:0] a, input logic [7:0] v);
    tb_mem[a]  = v;
    ref_mem[a] = v;
  endtask

  // One CPU bus cycle on unit u; holds strobes until wait is released
  task automatic bus_cycle(input int u, input bit io, input bit wr, input logic [15:0] a,
                           input logic [7:0] d, input int delay,
                           output logic [7:0] got, output int waits, output int pulses);
    int r0;
    bit hung;
    r0     = rises[u];
    dly[u] = delay;
    waits  = 0;
    hung   = 1'b1;
    @(negedge clk);
    cpu_a  = a;
    cpu_do = d;
    if (u == 0) begin
      if (io) iorq_n = 1'b0;
      else    mreq_n = 1'b0;
      rd_n = wr;
      wr_n = !wr;
    end else begin
      mreq2_n = 1'b0;
      rd2_n   = wr;
      wr2_n   = !wr;
    end
    for (int i = 0; i < 400; i++) begin
      #2;
      if (((u == 0) ? wait_n : wait2_n) === 1'b1) begin
        hung = 1'b0;
        break;
      end
      waits++;
      @(negedge clk);
    end
    check("bus_cycle_hang", 32'(hung), 32'd0);
    @(negedge clk);
    mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    mreq2_n = 1'b1; rd2_n = 1'b1; wr2_n = 1'b1;
    #2;
    got = (u == 0) ? cpu_di : cpu_di2;
    @(negedge clk);
    pulses = rises[u] - r0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  got;
    logic [7:0]  model_di;
    logic [15:0] a;
    logic [7:0]  d;
    int          waits, pulses, r0, delay;
    bit          wr;

    for (int i = 0; i < 65536; i++) begin
      tb_mem[i]  = 8'($urandom);
      ref_mem[i] = tb_mem[i];
    end
    cpu_a = 16'h0; cpu_do = 8'h0;
    mreq_n = 1'b0; rd_n = 1'b0; wr_n = 1'b1; iorq_n = 1'b1; m1_n = 1'b1; rfsh_n = 1'b1;
    mreq2_n = 1'b1; rd2_n = 1'b1; wr2_n = 1'b1;
    reset_n = 1'b0;

    // Reset state, with a read strobe active to show wait stays released
    repeat (3) @(negedge clk);
    #2;
    check("rst_wait_n",    32'(wait_n),    32'd1);
    check("rst_mem_req",   32'(mem_req),   32'd0);
    check("rst_mem_we",    32'(mem_we),    32'd0);
    check("rst_mem_addr",  32'(mem_addr),  32'h0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'h0);
    check("rst_cpu_di",    32'(cpu_di),    32'hFF);
    check("rst_bus_err",   32'(bus_err),   32'd0);
    check("rst_cpu_di2",   32'(cpu_di2),   32'hFF);
    check("rst_mem_req2",  32'(mem_req2),  32'd0);
    @(negedge clk);
    mreq_n = 1'b1; rd_n = 1'b1; reset_n = 1'b1;
    @(negedge clk);

    // SET 2,(HL): read B7 then write it back, immediate ack
    poke(16'h6029, 8'hB7);
    bus_cycle(0, 1'b0, 1'b0, 16'h6029, 8'h00, 1, got, waits, pulses);
    check("rmw_rd_data",   32'(got),    32'hB7);
    check("rmw_rd_waits",  32'(waits),  32'd2);
    check("rmw_rd_pulses", 32'(pulses), 32'd1);
    bus_cycle(0, 1'b0, 1'b1, 16'h6029, 8'hB7 | 8'h04, 1, got, waits, pulses);
    check("rmw_wr_addr",   32'(last_addr[0]),  32'h6029);
    check("rmw_wr_we",     32'(last_we[0]),    32'd1);
    check("rmw_wr_data",   32'(last_wdata[0]), 32'hB7);
    check("rmw_wr_pulses", 32'(pulses),        32'd1);
    check("rmw_wr_keepdi", 32'(got),           32'hB7);

    // Read at 0x0000 with the ack in the fifth request cycle
    poke(16'h0000, 8'hCB);
    bus_cycle(0, 1'b0, 1'b0, 16'h0000, 8'h00, 5, got, waits, pulses);
    check("slow_rd_waits",  32'(waits),  32'd6);
    check("slow_rd_data",   32'(got),    32'hCB);
    check("slow_rd_pulses", 32'(pulses), 32'd1);

    // Refresh cycle never starts an access
    r0 = rises[0];
    @(negedge clk);
    cpu_a = 16'h007F; mreq_n = 1'b0; rfsh_n = 1'b0; rd_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #2;
      check("rfsh_wait_n",  32'(wait_n),  32'd1);
      check("rfsh_mem_req", 32'(mem_req), 32'd0);
      @(negedge clk);
    end
    mreq_n = 1'b1; rfsh_n = 1'b1; rd_n = 1'b1;
    check("rfsh_pulses", 32'(rises[0] - r0), 32'd0);

    // Ack with no request outstanding is ignored
    @(negedge clk); #1 spur = 1'b1;
    @(negedge clk); #1 spur = 1'b0;
    @(negedge clk); #2;
    check("spur_cpu_di",  32'(cpu_di),  32'hCB);
    check("spur_mem_req", 32'(mem_req), 32'd0);

    // Interrupt acknowledge: no access, CPU sees 0xFF
    r0 = rises[0];
    @(negedge clk);
    iorq_n = 1'b0; m1_n = 1'b0; rd_n = 1'b0;
    #2;
    check("inta_wait_n", 32'(wait_n), 32'd1);
    @(negedge clk); #2;
    check("inta_cpu_di", 32'(cpu_di), 32'hFF);
    check("inta_wait_n2", 32'(wait_n), 32'd1);
    @(negedge clk);
    iorq_n = 1'b1; m1_n = 1'b1; rd_n = 1'b1;
    @(negedge clk);
    check("inta_pulses", 32'(rises[0] - r0), 32'd0);

    // OUT (0x29),A with A=A9, then IN A,(0x29)
    bus_cycle(0, 1'b1, 1'b1, {8'hA9, 8'h29}, 8'hA9, 1, got, waits, pulses);
`ifdef Z80_BRIDGE_IO_EN
    ref_mem[16'h1029] = 8'hA9;
    check("io_wr_pulses", 32'(pulses),        32'd1);
    check("io_wr_addr",   32'(last_addr[0]),  32'h1029);
    check("io_wr_data",   32'(last_wdata[0]), 32'hA9);
    check("io_wr_we",     32'(last_we[0]),    32'd1);
    check("io_wr_waits",  32'(waits),         32'd2);
`else
    check("io_wr_pulses", 32'(pulses), 32'd0);
    check("io_wr_waits",  32'(waits),  32'd0);
`endif
    poke(16'h1029, 8'h5A);
    bus_cycle(0, 1'b1, 1'b0, {8'h33, 8'h29}, 8'h00, 2, got, waits, pulses);
`ifdef Z80_BRIDGE_IO_EN
    check("io_rd_data",   32'(got),    32'h5A);
    check("io_rd_pulses", 32'(pulses), 32'd1);
    check("io_rd_waits",  32'(waits),  32'd3);
`else
    check("io_rd_data",   32'(got),    32'hFF);
    check("io_rd_pulses", 32'(pulses), 32'd0);
    check("io_rd_waits",  32'(waits),  32'd0);
`endif

    // Strobes dropped mid-request: request still completes
    poke(16'h4321, 8'h3C);
    dly[0] = 3;
    r0 = rises[0];
    @(negedge clk);
    cpu_a = 16'h4321; mreq_n = 1'b0; rd_n = 1'b0;
    @(negedge clk);
    mreq_n = 1'b1; rd_n = 1'b1;
    repeat (4) @(negedge clk);
    #2;
    check("abort_cpu_di",  32'(cpu_di),          32'h3C);
    check("abort_mem_req", 32'(mem_req),         32'd0);
    check("abort_pulses",  32'(rises[0] - r0),   32'd1);
    check("abort_wait_n",  32'(wait_n),          32'd1);

    // Reset while a request is outstanding
    en[0] = 1'b0;
    r0 = rises[0];
    @(negedge clk);
    cpu_a = 16'h0777; mreq_n = 1'b0; rd_n = 1'b0;
    @(negedge clk); @(negedge clk); #2;
    check("rstreq_pre_req",  32'(mem_req), 32'd1);
    check("rstreq_pre_wait", 32'(wait_n),  32'd0);
    reset_n = 1'b0;
    @(negedge clk); #2;
    check("rstreq_mem_req", 32'(mem_req), 32'd0);
    check("rstreq_cpu_di",  32'(cpu_di),  32'hFF);
    check("rstreq_wait_n",  32'(wait_n),  32'd1);
    @(negedge clk);
    mreq_n = 1'b1; rd_n = 1'b1; reset_n = 1'b1;
    en[0] = 1'b1;
    @(negedge clk); #1 spur = 1'b1;
    @(negedge clk); #1 spur = 1'b0;
    @(negedge clk); #2;
    check("rstreq_late_di",  32'(cpu_di),        32'hFF);
    check("rstreq_late_req", 32'(mem_req),       32'd0);
    check("rstreq_pulses",   32'(rises[0] - r0), 32'd1);

    // Unit 1: extra wait cycles, timeout, sticky error, ack in the last cycle
    poke(16'h2345, 8'h6E);
    bus_cycle(1, 1'b0, 1'b0, 16'h2345, 8'h00, 2, got, waits, pulses);
    check("xw_rd_data",  32'(got),      32'h6E);
    check("xw_rd_waits", 32'(waits),    32'd5);
    check("xw_bus_err",  32'(bus_err2), 32'd0);
    en[1] = 1'b0;
    bus_cycle(1, 1'b0, 1'b0, 16'h2345, 8'h00, 1, got, waits, pulses);
    check("to_waits",   32'(waits),    32'd5);
    check("to_cpu_di",  32'(got),      32'hFF);
    check("to_bus_err", 32'(bus_err2), 32'd1);
    check("to_mem_req", 32'(mem_req2), 32'd0);
    check("to_pulses",  32'(pulses),   32'd1);
    en[1] = 1'b1;
    bus_cycle(1, 1'b0, 1'b0, 16'h2346, 8'h00, 1, got, waits, pulses);
    check("sticky_data",    32'(got),      32'(ref_mem[16'h2346]));
    check("sticky_waits",   32'(waits),    32'd4);
    check("sticky_bus_err", 32'(bus_err2), 32'd1);
    @(negedge clk); reset_n = 1'b0;
    @(negedge clk); #2;
    check("err_clr_bus_err", 32'(bus_err2), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    bus_cycle(1, 1'b0, 1'b0, 16'h2347, 8'h00, 4, got, waits, pulses);
    check("edge_to_data",    32'(got),      32'(ref_mem[16'h2347]));
    check("edge_to_waits",   32'(waits),    32'd7);
    check("edge_to_bus_err", 32'(bus_err2), 32'd0);

    // Randomized traffic on unit 0 against the memory model
    model_di = 8'hFF;
    for (int n = 0; n < 40; n++) begin
      wr    = 1'($urandom);
      a     = ($urandom_range(0, 3) == 0) ? 16'($urandom) : {13'h0A00, 3'($urandom)};
      d     = 8'($urandom);
      delay = $urandom_range(1, 6);
      bus_cycle(0, 1'b0, wr, a, d, delay, got, waits, pulses);
      if (!wr) model_di = ref_mem[a];
      else     ref_mem[a] = d;
      check("rnd_cpu_di", 32'(got),          32'(model_di));
      check("rnd_waits",  32'(waits),        32'(delay + 1));
      check("rnd_pulses", 32'(pulses),       32'd1);
      check("rnd_addr",   32'(last_addr[0]), 32'(a));
      check("rnd_we",     32'(last_we[0]),   32'(wr));
      if (wr) check("rnd_wdata", 32'(last_wdata[0]), 32'(d));
    end
    check("rnd_bus_err", 32'(bus_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/z80_mem_bridge.md
Z80_MEM_BRIDGE -- requirements
Module: z80_mem_bridge

Interface
REQ-001 SHALL have parameter MIN_WAIT, default 0, meaning extra wait cycles inserted after each mem_ack (range 0-15).
REQ-002 SHALL have parameter TIMEOUT, default 255, meaning max cycles mem_req may wait for mem_ack (range 1-255).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have ports cpu_a  input 16, cpu_do  input 8, plus 1-bit inputs cpu_mreq_n, cpu_iorq_n, cpu_rd_n, cpu_wr_n, cpu_m1_n, cpu_rfsh_n; these carry the tv80s bus.
REQ-006 SHALL have port cpu_di  output  8  registered read data to the CPU.
REQ-007 SHALL have port cpu_wait_n  output  1  wait request to the CPU, active-low.
REQ-008 SHALL have ports mem_req output 1, mem_we output 1, mem_addr output 16, mem_wdata output 8; together they form the request to the memory.
REQ-009 SHALL have ports mem_ack input 1 and mem_rdata input 8; mem_rdata is valid only while mem_ack=1.
REQ-010 SHALL have port bus_err  output  1  sticky flag set on timeout.

Function
REQ-011 SHALL detect a memory access, start=1, when in IDLE with mreq_n=0, rfsh_n=1 and (rd_n=0 or wr_n=0); refresh cycles (rfsh_n=0) SHALL never start an access.
REQ-012 SHALL detect an IO access when in IDLE with iorq_n=0, m1_n=1 and (rd_n=0 or wr_n=0).
REQ-013 SHALL treat iorq_n=0 with m1_n=0 (interrupt acknowledge) as no access, and SHALL drive cpu_di=8'hFF in that case.
REQ-014 SHALL implement an FSM with states IDLE, REQ, XWAIT and DONE.
REQ-015 FSM transitions SHALL be: IDLE->REQ on start; REQ->XWAIT on mem_ack when MIN_WAIT>0; REQ->DONE on mem_ack when MIN_WAIT=0; XWAIT->DONE after MIN_WAIT cycles; DONE->IDLE when mreq_n=1 and iorq_n=1.
REQ-016 On start, SHALL register mem_addr, mem_we (wr_n=0) and mem_wdata=cpu_do, and SHALL assert mem_req on the following cycle.
REQ-017 mem_req, mem_addr, mem_we and mem_wdata SHALL hold stable until the cycle mem_ack=1 is sampled; mem_req SHALL be 0 in the next cycle.
REQ-018 mem_ack arriving while mem_req=0 SHALL be ignored.
REQ-019 On read ack, SHALL latch mem_rdata into cpu_di; cpu_di SHALL hold its value until the next read completes (writes leave it unchanged).
REQ-020 cpu_wait_n SHALL be combinational: 0 when (IDLE and start) or in REQ or XWAIT; 1 otherwise.
REQ-021 Minimum latency with start in cycle N: mem_req=1 in N+1; if ack in N+1, cpu_di is valid and cpu_wait_n=1 in N+2.
REQ-022 A timeout counter SHALL reset on entering REQ. If it reaches TIMEOUT without ack: drop mem_req, set bus_err, load cpu_di=8'hFF on reads, and go to DONE.
REQ-023 Strobes deasserting while in REQ SHALL NOT abort the memory request; the FSM SHALL finish via DONE.
REQ-024 If a new strobe is present when DONE->IDLE occurs, detection SHALL happen no earlier than the IDLE cycle, so each bus cycle produces exactly one request.

Reset
REQ-025 On clk rising edge with reset_n=0: FSM=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_di=8'hFF, bus_err=0, counters=0; cpu_wait_n SHALL be 1 during reset.
REQ-026 Reset asserted mid-operation SHALL abandon the request immediately; no ack SHALL be consumed afterwards.

Configuration
REQ-027 The macro Z80_BRIDGE_IO_EN SHALL select IO handling.
REQ-028 With Z80_BRIDGE_IO_EN defined: IO accesses SHALL be forwarded as memory requests with mem_addr={8'h10, cpu_a[7:0]}.
REQ-029 Without Z80_BRIDGE_IO_EN: IO accesses SHALL issue no mem_req; reads return cpu_di=8'hFF, writes are dropped, and cpu_wait_n stays 1.

Verification
REQ-030 Read-modify-write of SET 2,(HL) with HL=6029, mem[6029]=B7 and immediate ack -> read returns B7, then one write with addr 6029, wdata B7, we=1.
REQ-031 Read at 0x0000 with mem_ack delayed 5 cycles -> cpu_wait_n low for 6 cycles, cpu_di=CB, exactly one mem_req pulse.
REQ-032 Refresh cycle with mreq_n=0 and rfsh_n=0 -> mem_req stays 0 and cpu_wait_n stays 1.
REQ-033 With TIMEOUT=4 and no ack on a read -> after 4 cycles mem_req=0, bus_err=1, cpu_di=FF; bus_err is cleared only by reset_n=0.
REQ-034 OUT (0x29),A with A=A9: with Z80_BRIDGE_IO_EN -> write to addr 1029 with data A9; without the macro -> no mem_req is issued.
REQ-035 reset_n=0 asserted while in REQ -> next cycle FSM=IDLE, mem_req=0, cpu_di=FF; an ack arriving later is ignored.
